// File: rtl/dmem_mmio_bridge_if.sv
// Data-memory bus between the processor/RAM environment (master) and the MMIO bridge (slave).
// The master side owns the processor request and the RAM read data; the bridge owns the rest.
interface dmem_mmio_bridge_if #(
    parameter int unsigned DMEM_ADDR_W = 12
) ();
    logic [31:0]            address_dmem;
    logic [31:0]            data;
    logic                   wren;
    logic [31:0]            q_dmem;
    logic [DMEM_ADDR_W-1:0] mem_address;
    logic [31:0]            mem_data;
    logic                   mem_wren;
    logic [31:0]            mem_q;

    modport master (
        output address_dmem, data, wren, mem_q,
        input  q_dmem, mem_address, mem_data, mem_wren
    );

    modport slave (
        input  address_dmem, data, wren, mem_q,
        output q_dmem, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Routes processor dmem accesses to the data RAM or a 16-word MMIO bank (LED, switches,
// cycle counter, countdown timer, scratch) with matching one-cycle load latency.
module dmem_mmio_bridge #(
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
    parameter int unsigned DMEM_ADDR_W = 12,
    parameter int unsigned LED_WIDTH   = 8,
    parameter int unsigned SW_WIDTH    = 8,
    parameter bit          AUTO_RELOAD = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    dmem_mmio_bridge_if.slave    bus,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 timer_irq
);

    localparam logic [3:0] OFF_LED    = 4'd0;
    localparam logic [3:0] OFF_SW     = 4'd1;
    localparam logic [3:0] OFF_CYCLE  = 4'd2;
    localparam logic [3:0] OFF_TLOAD  = 4'd3;
    localparam logic [3:0] OFF_TCOUNT = 4'd4;
    localparam logic [3:0] OFF_TSTAT  = 4'd5;
    localparam logic [3:0] OFF_SCRAT  = 4'd6;

    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]          scratch_q, scratch_d;
    logic [31:0]          cycle_q;
    logic [31:0]          load_q, load_d;
    logic [31:0]          count_q, count_d;
    logic                 running_q, running_d;
    logic                 expired_q, expired_d;
    logic                 sel_q;
    logic [31:0]          rdata_q, rdata_d;

    logic       hit;
    logic [3:0] off;
    logic       wr_mmio;
    logic       wr_tload;
    logic       expire;

    assign hit      = (bus.address_dmem[31:4] == MMIO_BASE[31:4]);
    assign off      = bus.address_dmem[3:0];
    assign wr_mmio  = bus.wren & hit;
    assign wr_tload = wr_mmio & (off == OFF_TLOAD);

    assign bus.mem_address = bus.address_dmem[DMEM_ADDR_W-1:0];
    assign bus.mem_data    = bus.data;
    assign bus.mem_wren    = bus.wren & ~hit;
    assign bus.q_dmem      = sel_q ? rdata_q : bus.mem_q;

    assign led_out   = led_q;
    assign timer_irq = expired_q;

    always_comb begin
        rdata_d = '0;
        case (off)
            OFF_LED:    rdata_d[LED_WIDTH-1:0] = led_q;
            OFF_SW:     rdata_d[SW_WIDTH-1:0]  = sw_sync_q;
            OFF_CYCLE:  rdata_d = cycle_q;
            OFF_TLOAD:  rdata_d = load_q;
            OFF_TCOUNT: rdata_d = count_q;
            OFF_TSTAT:  rdata_d[1:0] = {running_q, expired_q};
            OFF_SCRAT:  rdata_d = scratch_q;
            default:    rdata_d = '0;
        endcase
    end

    always_comb begin
        led_d     = led_q;
        scratch_d = scratch_q;
        if (wr_mmio && off == OFF_LED)   led_d     = bus.data[LED_WIDTH-1:0];
        if (wr_mmio && off == OFF_SCRAT) scratch_d = bus.data;
    end

    // A TIMER_LOAD store pre-empts decrement/expiry in the same cycle.
    always_comb begin
        load_d    = load_q;
        count_d   = count_q;
        running_d = running_q;
        expire    = 1'b0;
        if (wr_tload) begin
            load_d    = bus.data;
            count_d   = bus.data;
            running_d = (bus.data != 32'd0);
        end else if (running_q) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else if (count_q == 32'd1) begin
                expire = 1'b1;
                if (AUTO_RELOAD) begin
                    count_d = load_q;
                end else begin
                    count_d   = '0;
                    running_d = 1'b0;
                end
            end
        end
        // Expiry beats a simultaneous write-1-to-clear.
        expired_d = expire |
                    (expired_q & ~(wr_mmio & (off == OFF_TSTAT) & bus.data[0]));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            scratch_q <= '0;
            cycle_q   <= '0;
            load_q    <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            sel_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            scratch_q <= scratch_d;
            cycle_q   <= cycle_q + 32'd1;
            load_q    <= load_d;
            count_q   <= count_d;
            running_q <= running_d;
            expired_q <= expired_d;
            sel_q     <= hit;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: RAM path, MMIO register map, timer expiry/W1C races,
// switch synchroniser latency and reset behaviour, against hand-computed values.
module tb_dmem_mmio_bridge;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic       clock;
    logic       reset;
    logic [7:0] sw_in;
    logic [7:0] led_out;
    logic       timer_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] ram [0:255];
    logic [31:0] cyc_a, cyc_b;

    dmem_mmio_bridge_if #(.DMEM_ADDR_W(12)) bus ();

    dmem_mmio_bridge #(
        .MMIO_BASE   (BASE),
        .DMEM_ADDR_W (12),
        .LED_WIDTH   (8),
        .SW_WIDTH    (8),
        .AUTO_RELOAD (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM with one-clock read latency.
    always @(posedge clock) begin
        if (bus.mem_wren) ram[bus.mem_address[7:0]] <= bus.mem_data;
        if (reset) bus.mem_q <= '0;
        else       bus.mem_q <= ram[bus.mem_address[7:0]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset            = 1'b1;
        sw_in            = '0;
        bus.address_dmem = '0;
        bus.data         = '0;
        bus.wren         = 1'b0;
        repeat (2) tick();
        check("rst_q_dmem", bus.q_dmem, 32'h0);
        check("rst_led", {24'h0, led_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        reset = 1'b0;

        // RAM store/load
        bus.address_dmem = 32'd5; bus.data = 32'h1234_5678; bus.wren = 1'b1;
        #1;
        check("ram_wren", {31'h0, bus.mem_wren}, 32'h1);
        check("ram_addr", {20'h0, bus.mem_address}, 32'h5);
        tick();
        bus.wren = 1'b0;
        tick();
        check("ram_load", bus.q_dmem, 32'h1234_5678);

        // Decode boundaries: just past and just below the window go to RAM
        bus.address_dmem = BASE + 32'd16; bus.data = 32'h0; bus.wren = 1'b1;
        #1;
        check("dec_above", {31'h0, bus.mem_wren}, 32'h1);
        bus.address_dmem = BASE - 32'd1;
        #1;
        check("dec_below", {31'h0, bus.mem_wren}, 32'h1);
        bus.wren = 1'b0;

        // LED
        bus.address_dmem = BASE; bus.data = 32'h0000_01A5; bus.wren = 1'b1;
        #1;
        check("led_wren", {31'h0, bus.mem_wren}, 32'h0);
        tick();
        check("led_out", {24'h0, led_out}, 32'hA5);
        bus.wren = 1'b0;
        tick();
        check("led_load", bus.q_dmem, 32'h0000_00A5);

        // SCRATCH and an unmapped offset
        bus.address_dmem = BASE + 32'd6; bus.data = 32'hDEAD_BEEF; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0;
        tick();
        check("scratch", bus.q_dmem, 32'hDEAD_BEEF);
        bus.address_dmem = BASE + 32'd7; bus.data = 32'hFFFF_FFFF; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0;
        tick();
        check("unmapped", bus.q_dmem, 32'h0);

        // Timer: load 3, auto-reload
        bus.address_dmem = BASE + 32'd3; bus.data = 32'd3; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0; bus.address_dmem = BASE + 32'd4;
        tick();
        check("cnt_e0", bus.q_dmem, 32'd3);
        tick();
        check("cnt_e1", bus.q_dmem, 32'd2);
        tick();
        check("cnt_e2", bus.q_dmem, 32'd1);
        check("irq_exp", {31'h0, timer_irq}, 32'h1);
        tick();
        check("cnt_reload", bus.q_dmem, 32'd3);
        bus.address_dmem = BASE + 32'd5;
        tick();
        check("status", bus.q_dmem, 32'h3);

        // W1C racing with expiry: set wins, then a later W1C clears
        bus.data = 32'h1; bus.wren = 1'b1;
        tick();
        check("w1c_race", {31'h0, timer_irq}, 32'h1);
        tick();
        check("w1c_clear", {31'h0, timer_irq}, 32'h0);
        bus.address_dmem = BASE + 32'd3; bus.data = 32'h0;
        tick();
        bus.wren = 1'b0; bus.address_dmem = BASE + 32'd5;
        tick();
        check("stop_status", bus.q_dmem, 32'h0);

        // Switch synchroniser
        sw_in = 8'h5A;
        tick();
        bus.address_dmem = BASE + 32'd1;
        tick();
        check("sw_early", bus.q_dmem, 32'h0);
        tick();
        check("sw_sync", bus.q_dmem, 32'h5A);

        // CYCLE difference
        bus.address_dmem = BASE + 32'd2;
        tick();
        cyc_a = bus.q_dmem;
        repeat (7) tick();
        cyc_b = bus.q_dmem;
        check("cycle_diff", cyc_b - cyc_a, 32'd7);

        // Reset mid-countdown, with a competing LED store
        bus.address_dmem = BASE; bus.data = 32'h3C; bus.wren = 1'b1;
        tick();
        bus.address_dmem = BASE + 32'd3; bus.data = 32'd10;
        tick();
        bus.wren = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        bus.address_dmem = BASE; bus.data = 32'hFF; bus.wren = 1'b1;
        tick();
        reset = 1'b0; bus.wren = 1'b0;
        check("rst2_led", {24'h0, led_out}, 32'h0);
        check("rst2_irq", {31'h0, timer_irq}, 32'h0);
        bus.address_dmem = BASE + 32'd2;
        tick();
        check("rst2_cycle", bus.q_dmem, 32'h0);
        bus.address_dmem = BASE + 32'd4;
        tick();
        check("rst2_count", bus.q_dmem, 32'h0);
        bus.address_dmem = BASE + 32'd5;
        tick();
        check("rst2_status", bus.q_dmem, 32'h0);
        repeat (12) tick();
        check("rst2_noexp", {31'h0, timer_irq}, 32'h0);
        bus.address_dmem = 32'd5;
        tick();
        check("rst2_ram", bus.q_dmem, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
